// File: rtl/tau_stream.sv
// Streaming N x N transpose with ping-pong banks: one row in and one transposed row out per beat.
// Optional TAU_STREAM_BYPASS_EN adds a per-matrix bypass input that passes rows through unchanged.
module tau_stream #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_row,
`ifdef TAU_STREAM_BYPASS_EN
  input  logic           bypass,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_row,
  output logic           out_last
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [N*W-1:0] bank_q [2][N];
  logic [1:0]     full_q, full_d;
  logic           wr_sel_q, wr_sel_d;
  logic           rd_sel_q, rd_sel_d;
  logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
  logic           wr_fire, rd_fire;
  logic [N*W-1:0] src_row;

  assign in_ready  = !rst && !full_q[wr_sel_q];
  assign out_valid = !rst && full_q[rd_sel_q];
  assign out_last  = out_valid && (rd_cnt_q == LAST);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  // Write completion and read completion always hit different banks, so both edits apply.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (wr_fire) begin
      if (wr_cnt_q == LAST) begin
        wr_cnt_d         = '0;
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = !wr_sel_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
    if (rd_fire) begin
      if (rd_cnt_q == LAST) begin
        rd_cnt_d         = '0;
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = !rd_sel_q;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignments here so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // NOTE: bank storage is deliberately not reset; the full flags decide what is ever read.
  always_ff @(posedge clk) begin
    if (wr_fire) bank_q[wr_sel_q][wr_cnt_q] <= in_row;
  end

`ifdef TAU_STREAM_BYPASS_EN
  logic [1:0] byp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q <= '0;
    end else if (wr_fire && wr_cnt_q == '0) begin
      byp_q[wr_sel_q] <= bypass;
    end
  end
`endif

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    out_row = '0;
    src_row = '0;
    for (int j = 0; j < N; j++) begin
      src_row = bank_q[rd_sel_q][j];
      out_row[N*W-1-j*W -: W] = src_row[N*W-1-int'(rd_cnt_q)*W -: W];
    end
`ifdef TAU_STREAM_BYPASS_EN
    if (byp_q[rd_sel_q]) out_row = bank_q[rd_sel_q][rd_cnt_q];
`endif
  end

endmodule

// File: tb/tb_tau_stream.sv
// Self-checking bench for tau_stream: a matrix-level queue model checks every cycle of the
// N=4/W=8 instance; a second N=8/W=16 instance is checked against its closed-form transpose.
module tb_tau_stream;

  localparam int N4 = 4;
  localparam int W4 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, out_valid, out_ready, out_last, bypass;
  logic [31:0]  in_row, out_row;
  logic         in8_valid, in8_ready, out8_valid, out8_ready, out8_last;
  logic [127:0] in8_row, out8_row;
`ifdef TAU_STREAM_BYPASS_EN
  logic         bypass8;
`endif

  tau_stream #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
`ifdef TAU_STREAM_BYPASS_EN
    .bypass(bypass),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_last(out_last)
  );

  tau_stream #(.N(8), .W(16)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in8_valid), .in_ready(in8_ready), .in_row(in8_row),
`ifdef TAU_STREAM_BYPASS_EN
    .bypass(bypass8),
`endif
    .out_valid(out8_valid), .out_ready(out8_ready), .out_row(out8_row), .out_last(out8_last)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] exp_q[$];
  logic [127:0] cur_rows [8];
  int           cur_cnt  = 0;
  logic         cur_byp  = 1'b0;
  int           out_idx  = 0;
  logic         in_fired = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] elem(input logic [127:0] row, input int n, input int w,
                                        input int k);
    logic [127:0] mask;
    mask = (128'd1 << w) - 128'd1;
    return (row >> ((n - 1 - k) * w)) & mask;
  endfunction

  // Output row c of a transpose: element j is element c of source row j.
  function automatic logic [127:0] xpose(input logic [127:0] m [8], input int n, input int w,
                                         input int c);
    logic [127:0] res;
    res = '0;
    for (int j = 0; j < n; j++) res = (res << w) | elem(m[j], n, w, c);
    return res;
  endfunction

  // One clock of the N=4 instance: check outputs against the model, then advance the model.
  task automatic tick();
    int   occ;
    logic fire_in, fire_out;
    #1;
    occ = (exp_q.size() + N4 - 1) / N4;
    if (rst) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
    end else begin
      check("in_ready", in_ready, occ < 2);
      check("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        check("out_row", out_row, exp_q[0]);
        check("out_last", out_last, out_idx == N4 - 1);
      end
    end
    fire_in  = !rst && in_valid && (occ < 2);
    fire_out = !rst && out_ready && (exp_q.size() > 0);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      cur_cnt = 0;
      out_idx = 0;
    end else begin
      if (fire_out) begin
        void'(exp_q.pop_front());
        out_idx = (out_idx + 1) % N4;
      end
      if (fire_in) begin
        if (cur_cnt == 0) cur_byp = bypass;
        cur_rows[cur_cnt] = 128'(in_row);
        cur_cnt++;
        if (cur_cnt == N4) begin
          for (int c = 0; c < N4; c++)
            exp_q.push_back(cur_byp ? cur_rows[c] : xpose(cur_rows, N4, W4, c));
          cur_cnt = 0;
        end
      end
    end
    in_fired = fire_in;
    #1;
  endtask

  task automatic push_row(input logic [31:0] row, output int ticks);
    in_valid = 1'b1;
    in_row   = row;
    ticks    = 0;
    in_fired = 1'b0;
    while (!in_fired && ticks < 50) begin
      tick();
      ticks++;
    end
    if (!in_fired) check("push_timeout", in_fired, 1);
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() > 0 && k < 100) begin
      tick();
      k++;
    end
    check("drain_done", exp_q.size(), 0);
    tick();
  endtask

  logic [31:0]  basic_rows [4] = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
  logic [31:0]  rst_rows   [4] = '{32'hA0A1A2A3, 32'hA4A5A6A7, 32'hA8A9AAAB, 32'hB0B1B2B3};

  initial begin
    int           t;
    int           got;
    logic [127:0] row8;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_row = '0; bypass = 1'b0;
    in8_valid = 1'b0; out8_ready = 1'b0; in8_row = '0;
`ifdef TAU_STREAM_BYPASS_EN
    bypass8 = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic transpose
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) push_row(basic_rows[r], t);
    in_valid = 1'b0;
    check("basic_first_valid", out_valid, 1);
    check("basic_first_row", out_row, 32'h0105090D);
    drain();

    // Three back-to-back matrices with no stall
    out_ready = 1'b1;
    for (int r = 0; r < 12; r++) begin
      push_row($urandom, t);
      check("stream_no_stall", t, 1);
    end
    drain();

    // Back-pressure: both banks fill, then drain
    out_ready = 1'b0;
    for (int r = 0; r < 4; r++) push_row(basic_rows[r], t);
    for (int r = 0; r < 4; r++) push_row($urandom, t);
    in_valid = 1'b0;
    check("bp_in_ready_low", in_ready, 0);
    check("bp_hold_row", out_row, 32'h0105090D);
    for (int k = 0; k < 3; k++) tick();
    check("bp_hold_row_later", out_row, 32'h0105090D);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("bp_ready_back", in_ready, 1);
    drain();

    // Reset mid-matrix discards the partial matrix
    out_ready = 1'b1;
    push_row(32'h11223344, t);
    push_row(32'h55667788, t);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_out_valid", out_valid, 0);
    for (int r = 0; r < 4; r++) push_row(rst_rows[r], t);
    in_valid = 1'b0;
    check("rst_mid_first_row", out_row, 32'hA0A4A8B0);
    drain();

`ifdef TAU_STREAM_BYPASS_EN
    // Bypass matrix followed by a transposed matrix
    out_ready = 1'b1;
    bypass = 1'b1;
    for (int r = 0; r < 4; r++) push_row(basic_rows[r], t);
    bypass = 1'b0;
    for (int r = 0; r < 4; r++) push_row(basic_rows[r], t);
    drain();
`endif

    // Random traffic on both sides
    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_row    = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef TAU_STREAM_BYPASS_EN
      bypass    = 1'($urandom_range(0, 1));
`endif
      tick();
    end
    drain();

    // N=8, W=16: element k of row j is {j, k}
    for (int j = 0; j < 8; j++) begin
      row8 = '0;
      for (int k = 0; k < 8; k++) row8 = (row8 << 16) | 128'({8'(j), 8'(k)});
      in8_valid = 1'b1;
      in8_row   = row8;
      t = 0;
      while (!in8_ready && t < 20) begin
        tick();
        t++;
      end
      check("p8_in_ready", in8_ready, 1);
      tick();
    end
    in8_valid  = 1'b0;
    out8_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
      if (out8_valid) begin
        row8 = '0;
        for (int j = 0; j < 8; j++) row8 = (row8 << 16) | 128'({8'(j), 8'(got)});
        check("p8_out_row", out8_row, row8);
        check("p8_out_last", out8_last, got == 7);
        got++;
      end
      tick();
    end
    check("p8_count", got, 8);
    check("p8_idle", out8_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
